// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and read-owner codes.
package dm_arb_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating starvation counter: clear wins over increment; hit flags that this
// increment reaches LIMIT.
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                inc,
    output logic [STARVE_W-1:0] cnt,
    output logic                hit
);

    localparam logic [STARVE_W-1:0] LIM    = STARVE_W'(LIMIT);
    localparam logic [STARVE_W-1:0] LIM_M1 = STARVE_W'(LIMIT - 1);

    assign hit = inc && (cnt >= LIM_M1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the data-memory port between the core and DMA, with a starvation-forced
// DMA slot and read-data return routing. Optional statistics: define DM_ARB_STATS_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DMA_SIZE     = 16,
    parameter int DMD_SIZE     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dm_cslt,
    input  logic                ps_dm_wrb,
    input  logic [DMA_SIZE-1:0] dg_dm_add,
    input  logic [DMD_SIZE-1:0] bc_dt,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [DMD_SIZE-1:0] dma_wdt,
    output logic                dma_gnt,
    output logic [DMD_SIZE-1:0] dma_rdt,
    output logic                dma_rvld,
    output logic [DMD_SIZE-1:0] ps_rdt,
    output logic                ps_rvld,
    output logic                arb_ps_stall,
    output logic                arb_dm_cslt,
    output logic                arb_dm_wrb,
    output logic [DMA_SIZE-1:0] arb_dm_add,
    output logic [DMD_SIZE-1:0] arb_dm_wdt,
    input  logic [DMD_SIZE-1:0] dm_rdt
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]         conflict_cnt,
    output logic [15:0]         force_cnt
`endif
);

    arb_state_t            st;
    owner_t                rd_owner;
    logic                  core_sel, dma_sel, stall_raw;
    logic                  starve_inc, starve_hit;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [DMD_SIZE-1:0]   ps_rdt_q, dma_rdt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        core_sel  = 1'b0;
        dma_sel   = 1'b0;
        stall_raw = 1'b0;
        if (st == ST_NORMAL) begin
            core_sel = ps_dm_cslt;
            dma_sel  = !ps_dm_cslt && dma_req;
        end else begin
            dma_sel   = dma_req;
            stall_raw = ps_dm_cslt && dma_req;
        end
    end

    assign starve_inc = (st == ST_NORMAL) && ps_dm_cslt && dma_req;

    dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr   (!starve_inc),
        .inc   (starve_inc),
        .cnt   (starve_cnt),
        .hit   (starve_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= ST_NORMAL;
            rd_owner  <= OWN_NONE;
            ps_rdt_q  <= '0;
            dma_rdt_q <= '0;
        end else begin
            st <= (st == ST_NORMAL && starve_hit) ? ST_FORCE : ST_NORMAL;
            if (core_sel && ps_dm_wrb)     rd_owner <= OWN_CORE;
            else if (dma_sel && dma_wrb)   rd_owner <= OWN_DMA;
            else                           rd_owner <= OWN_NONE;
            if (rd_owner == OWN_CORE) ps_rdt_q  <= dm_rdt;
            if (rd_owner == OWN_DMA)  dma_rdt_q <= dm_rdt;
        end
    end

    // NOTE: the combinational port outputs are forced to zero while reset is low, not just the flops.
    always_comb begin
        dma_gnt      = 1'b0;
        arb_ps_stall = 1'b0;
        arb_dm_cslt  = 1'b0;
        arb_dm_wrb   = 1'b0;
        arb_dm_add   = '0;
        arb_dm_wdt   = '0;
        ps_rvld      = 1'b0;
        dma_rvld     = 1'b0;
        ps_rdt       = '0;
        dma_rdt      = '0;
        if (reset) begin
            dma_gnt      = dma_sel;
            arb_ps_stall = stall_raw;
            arb_dm_cslt  = core_sel || dma_sel;
            if (core_sel) begin
                arb_dm_wrb = ps_dm_wrb;
                arb_dm_add = dg_dm_add;
                arb_dm_wdt = bc_dt;
            end else if (dma_sel) begin
                arb_dm_wrb = dma_wrb;
                arb_dm_add = dma_add;
                arb_dm_wdt = dma_wdt;
            end
            ps_rvld  = (rd_owner == OWN_CORE);
            dma_rvld = (rd_owner == OWN_DMA);
            ps_rdt   = ps_rvld  ? dm_rdt : ps_rdt_q;
            dma_rdt  = dma_rvld ? dm_rdt : dma_rdt_q;
        end
    end

`ifdef DM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
            force_cnt    <= '0;
        end else begin
            if (ps_dm_cslt && dma_req) conflict_cnt <= conflict_cnt + 16'd1;
            if (st == ST_FORCE)        force_cnt    <= force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: scenario tasks with inline checks, plus a
// read-return scoreboard fed by the tasks and drained by a negedge monitor.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_dm_cslt, ps_dm_wrb;
    logic [15:0] dg_dm_add, bc_dt;
    logic        dma_req, dma_wrb;
    logic [15:0] dma_add, dma_wdt;
    logic        dma_gnt, dma_rvld, ps_rvld, arb_ps_stall, arb_dm_cslt, arb_dm_wrb;
    logic [15:0] dma_rdt, ps_rdt, arb_dm_add, arb_dm_wdt;
    logic [15:0] dm_rdt = 16'h0;
`ifdef DM_ARB_STATS_EN
    logic [15:0] conflict_cnt, force_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          core;
        logic [15:0] data;
        int          due;
    } rd_exp_t;
    rd_exp_t sb[$];

    logic [15:0] mem [0:255];

    dm_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .ps_dm_cslt   (ps_dm_cslt),
        .ps_dm_wrb    (ps_dm_wrb),
        .dg_dm_add    (dg_dm_add),
        .bc_dt        (bc_dt),
        .dma_req      (dma_req),
        .dma_wrb      (dma_wrb),
        .dma_add      (dma_add),
        .dma_wdt      (dma_wdt),
        .dma_gnt      (dma_gnt),
        .dma_rdt      (dma_rdt),
        .dma_rvld     (dma_rvld),
        .ps_rdt       (ps_rdt),
        .ps_rvld      (ps_rvld),
        .arb_ps_stall (arb_ps_stall),
        .arb_dm_cslt  (arb_dm_cslt),
        .arb_dm_wrb   (arb_dm_wrb),
        .arb_dm_add   (arb_dm_add),
        .arb_dm_wdt   (arb_dm_wdt),
        .dm_rdt       (dm_rdt)
`ifdef DM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory block model: synchronous write, read data valid the cycle after the select.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arb_dm_cslt) begin
            if (arb_dm_wrb) dm_rdt <= mem[arb_dm_add[7:0]];
            else            mem[arb_dm_add[7:0]] <= arb_dm_wdt;
        end
    end

    // Read-return monitor.
    initial begin
        rd_exp_t ent;
        logic    exp_ps, exp_dma;
        logic [15:0] exp_dt;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_ps = 1'b0; exp_dma = 1'b0; exp_dt = 16'h0;
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    ent = sb.pop_front();
                    total++; bad++;
                    $display("FAIL rd_return_missed: due cycle %0d, now %0d", ent.due, cyc);
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    ent = sb.pop_front();
                    exp_ps = ent.core; exp_dma = !ent.core; exp_dt = ent.data;
                end
                if (ps_rvld || dma_rvld || exp_ps || exp_dma) begin
                    total++;
                    if (ps_rvld !== exp_ps || dma_rvld !== exp_dma) begin
                        bad++;
                        $display("FAIL rvld cyc=%0d: got ps=%b dma=%b, want ps=%b dma=%b",
                                 cyc, ps_rvld, dma_rvld, exp_ps, exp_dma);
                    end else if (exp_ps && ps_rdt !== exp_dt) begin
                        bad++;
                        $display("FAIL ps_rdt cyc=%0d: got %h want %h", cyc, ps_rdt, exp_dt);
                    end else if (exp_dma && dma_rdt !== exp_dt) begin
                        bad++;
                        $display("FAIL dma_rdt cyc=%0d: got %h want %h", cyc, dma_rdt, exp_dt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic cs, input logic wrb, input logic [15:0] add, input logic [15:0] dt);
        ps_dm_cslt = cs; ps_dm_wrb = wrb; dg_dm_add = add; bc_dt = dt;
    endtask

    task automatic set_dma(input logic req, input logic wrb, input logic [15:0] add, input logic [15:0] wdt);
        dma_req = req; dma_wrb = wrb; dma_add = add; dma_wdt = wdt;
    endtask

    task automatic set_idle();
        set_core(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic push_rd(input bit core, input logic [15:0] data);
        rd_exp_t e;
        e.core = core; e.data = data; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        reset = 1'b0;
        set_core(1'b1, 1'b0, 16'h0030, 16'hC0DE);
        set_dma(1'b1, 1'b1, 16'h0031, 16'h0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        outs = {dma_gnt, arb_ps_stall, arb_dm_cslt, arb_dm_wrb, ps_rvld, dma_rvld,
                arb_dm_add, arb_dm_wdt, ps_rdt, dma_rdt};
        total++;
        if (outs !== 70'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (arb_dm_cslt !== 1'b1 || dma_gnt !== 1'b0 || arb_dm_add !== 16'h0030 || arb_dm_wdt !== 16'hC0DE) begin
            bad++;
            $display("FAIL release_core_grant: cslt=%b gnt=%b add=%h wdt=%h want 1 0 0030 c0de",
                     arb_dm_cslt, dma_gnt, arb_dm_add, arb_dm_wdt);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_core_read();
        set_core(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        @(negedge clk);
        total++;
        if (arb_dm_cslt !== 1'b1 || arb_dm_wrb !== 1'b0 || arb_dm_wdt !== 16'hBEEF) begin
            bad++;
            $display("FAIL core_write: cslt=%b wrb=%b wdt=%h want 1 0 beef", arb_dm_cslt, arb_dm_wrb, arb_dm_wdt);
        end
        next_cycle();
        set_core(1'b1, 1'b1, 16'h0010, 16'h0);
        push_rd(1'b1, 16'hBEEF);
        @(negedge clk);
        total++;
        if (arb_dm_add !== 16'h0010 || arb_dm_wrb !== 1'b1 || dma_gnt !== 1'b0) begin
            bad++;
            $display("FAIL core_read_port: add=%h wrb=%b gnt=%b want 0010 1 0", arb_dm_add, arb_dm_wrb, dma_gnt);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_dma_write();
        set_dma(1'b1, 1'b0, 16'h0020, 16'h1234);
        @(negedge clk);
        total++;
        if (dma_gnt !== 1'b1 || arb_dm_wdt !== 16'h1234 || arb_dm_wrb !== 1'b0 ||
            arb_dm_add !== 16'h0020 || arb_ps_stall !== 1'b0) begin
            bad++;
            $display("FAIL dma_write: gnt=%b wdt=%h wrb=%b add=%h stall=%b want 1 1234 0 0020 0",
                     dma_gnt, arb_dm_wdt, arb_dm_wrb, arb_dm_add, arb_ps_stall);
        end
        next_cycle();
        set_dma(1'b1, 1'b1, 16'h0020, 16'h0);
        push_rd(1'b0, 16'h1234);
        @(negedge clk);
        total++;
        if (dma_gnt !== 1'b1 || arb_dm_wrb !== 1'b1) begin
            bad++;
            $display("FAIL dma_read_grant: gnt=%b wrb=%b want 1 1", dma_gnt, arb_dm_wrb);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_starvation();
        // A DMA grant between conflict bursts must restart the count.
        for (int i = 0; i < 2; i++) begin
            set_core(1'b1, 1'b0, 16'h0040, 16'h0040);
            set_dma(1'b1, 1'b0, 16'h0041, 16'h7777);
            @(negedge clk);
            total++;
            if (dma_gnt !== 1'b0) begin
                bad++;
                $display("FAIL pre_conflict_%0d: gnt=%b want 0", i, dma_gnt);
            end
            next_cycle();
        end
        set_core(1'b0, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        total++;
        if (dma_gnt !== 1'b1) begin
            bad++;
            $display("FAIL idle_slot_grant: gnt=%b want 1", dma_gnt);
        end
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            set_core(1'b1, 1'b0, 16'h0040, 16'h0040);
            @(negedge clk);
            total++;
            if (dma_gnt !== 1'b0 || arb_ps_stall !== 1'b0 || arb_dm_add !== 16'h0040) begin
                bad++;
                $display("FAIL starve_cycle_%0d: gnt=%b stall=%b add=%h want 0 0 0040",
                         i, dma_gnt, arb_ps_stall, arb_dm_add);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (dma_gnt !== 1'b1 || arb_ps_stall !== 1'b1 || arb_dm_cslt !== 1'b1 ||
            arb_dm_add !== 16'h0041 || arb_dm_wdt !== 16'h7777) begin
            bad++;
            $display("FAIL force_slot: gnt=%b stall=%b cslt=%b add=%h wdt=%h want 1 1 1 0041 7777",
                     dma_gnt, arb_ps_stall, arb_dm_cslt, arb_dm_add, arb_dm_wdt);
        end
        next_cycle();
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        total++;
        if (dma_gnt !== 1'b0 || arb_ps_stall !== 1'b0 || arb_dm_add !== 16'h0040 || arb_dm_cslt !== 1'b1) begin
            bad++;
            $display("FAIL after_force: gnt=%b stall=%b add=%h cslt=%b want 0 0 0040 1",
                     dma_gnt, arb_ps_stall, arb_dm_add, arb_dm_cslt);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_interleaved();
        set_core(1'b1, 1'b0, 16'h0001, 16'hAAAA);
        next_cycle();
        set_core(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b1, 1'b0, 16'h0002, 16'h5555);
        next_cycle();
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        set_core(1'b1, 1'b1, 16'h0001, 16'h0);
        push_rd(1'b1, 16'hAAAA);
        next_cycle();
        set_core(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b1, 1'b1, 16'h0002, 16'h0);
        push_rd(1'b0, 16'h5555);
        next_cycle();
        set_idle();
        @(negedge clk);
        total++;
        if (ps_rdt !== 16'hAAAA) begin
            bad++;
            $display("FAIL ps_rdt_hold: got %h want aaaa", ps_rdt);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (dma_rdt !== 16'h5555 || ps_rdt !== 16'hAAAA) begin
            bad++;
            $display("FAIL rdt_hold_idle: dma=%h ps=%h want 5555 aaaa", dma_rdt, ps_rdt);
        end
        next_cycle();
    endtask

    task automatic test_reset_in_force();
        set_dma(1'b1, 1'b1, 16'h0002, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            set_core(1'b1, 1'b0, 16'h0050, 16'h0050);
            next_cycle();
        end
        set_core(1'b1, 1'b1, 16'h0001, 16'h0);
        next_cycle();
        // Now in the forced slot, with the core's read return due this cycle.
        #1;
        total++;
        if (arb_ps_stall !== 1'b1 || dma_gnt !== 1'b1 || ps_rvld !== 1'b1) begin
            bad++;
            $display("FAIL force_before_reset: stall=%b gnt=%b ps_rvld=%b want 1 1 1",
                     arb_ps_stall, dma_gnt, ps_rvld);
        end
        reset = 1'b0;
        #1;
        total++;
        if (arb_ps_stall !== 1'b0 || dma_gnt !== 1'b0 || arb_dm_cslt !== 1'b0 ||
            ps_rvld !== 1'b0 || arb_dm_add !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: stall=%b gnt=%b cslt=%b ps_rvld=%b add=%h want 0 0 0 0 0000",
                     arb_ps_stall, dma_gnt, arb_dm_cslt, ps_rvld, arb_dm_add);
        end
        set_idle();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (ps_rvld !== 1'b0 || dma_rvld !== 1'b0 || arb_ps_stall !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_%0d: ps_rvld=%b dma_rvld=%b stall=%b want 0 0 0",
                         i, ps_rvld, dma_rvld, arb_ps_stall);
            end
        end
        next_cycle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_core_read();
        test_dma_write();
        test_starvation();
        test_interleaved();
        test_reset_in_force();
        repeat (2) next_cycle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core (PS chip-select plus DAG address and broadcast-bus write data) and an external DMA/host port.
- Core has fixed priority. A starvation counter forces a DMA slot after STARVE_LIMIT denied cycles and stalls the core for that slot.
- Sits between PS/DAG/BC and the memory block.
- Also routes read data back to the requester that issued the read.

Parameters:
- DMA_SIZE, 16, data-memory address width.
- DMD_SIZE, 16, data-memory data width.
- STARVE_LIMIT, 4, consecutive denied DMA cycles before a forced DMA slot; legal range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps_dm_cslt  in  1  core data-memory request.
- ps_dm_wrb  in  1  core direction: 1 = read, 0 = write.
- dg_dm_add  in  DMA_SIZE  core address from DAG.
- bc_dt  in  DMD_SIZE  core write data.
- dma_req  in  1  DMA request; held with add/wrb/wdt stable until granted.
- dma_wrb  in  1  DMA direction: 1 = read, 0 = write.
- dma_add  in  DMA_SIZE  DMA address.
- dma_wdt  in  DMD_SIZE  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdt  out  DMD_SIZE  DMA read data.
- dma_rvld  out  1  dma_rdt valid.
- ps_rdt  out  DMD_SIZE  core read data.
- ps_rvld  out  1  ps_rdt valid.
- arb_ps_stall  out  1  core must hold its request; not serviced this cycle.
- arb_dm_cslt  out  1  memory chip-select.
- arb_dm_wrb  out  1  memory direction.
- arb_dm_add  out  DMA_SIZE  memory address.
- arb_dm_wdt  out  DMD_SIZE  memory write data.
- dm_rdt  in  DMD_SIZE  memory read data, valid one cycle after a read select.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to NORMAL; starve_cnt=0; rd_owner=NONE.
  - All outputs are 0, including the combinational memory-port outputs, which are gated by reset.
- State machine has two states, NORMAL and FORCE.
- NORMAL:
  - If ps_dm_cslt=1: core owns the port and memory outputs mux the core signals. dma_gnt=0.
  - If dma_req=1 in the same cycle, starve_cnt increments.
  - If ps_dm_cslt=0 and dma_req=1: DMA owns the port, dma_gnt=1, starve_cnt clears.
  - If neither requests: arb_dm_cslt=0 and starve_cnt clears.
  - Transition to FORCE on the edge where the incremented starve_cnt equals STARVE_LIMIT.
- FORCE:
  - DMA owns the port; dma_gnt=1 when dma_req=1.
  - arb_ps_stall=1 if ps_dm_cslt=1.
  - starve_cnt clears. Next state is NORMAL unconditionally.
  - If dma_req dropped, which is illegal but tolerated: arb_dm_cslt=0, no stall, return to NORMAL.
- Grant timing:
  - Grant and port mux are combinational in the request cycle, so there is no added latency for the core.
  - State, counter and rd_owner are registered.
- Read return:
  - rd_owner (2 bits: NONE/CORE/DMA) records who issued a read select, on every edge.
  - Next cycle: dm_rdt is presented on the owner's rdt output, and that owner's rvld pulses for 1 cycle.
  - The non-owner's rdt holds its previous value.
- Writes: no return pulse. A write in cycle N followed by a read of the same address in N+1 returns the new data; this is memory behaviour and is not modified.
- Back-to-back traffic: alternating owners in consecutive cycles is legal. Each read is routed independently through rd_owner.
- Reset mid-read: the pending rvld is discarded.
- starve_cnt saturates at STARVE_LIMIT and never wraps.

Optional Feature:
- Macro DM_ARB_STATS_EN.
- When defined, adds two outputs:
  - conflict_cnt (16 bits): cycles with both requests asserted.
  - force_cnt (16 bits): FORCE-state cycles.
  - Both wrap at 0xFFFF→0 and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dm_arb_pkg holds:
  - State encoding constants ST_NORMAL=1'b0, ST_FORCE=1'b1.
  - Owner codes OWN_NONE=2'd0, OWN_CORE=2'd1, OWN_DMA=2'd2.
- One natural sub-module, dm_arb_starve_ctr: saturating counter with clear/increment and a limit-reached output.

Test Plan:
- Reset values: hold reset=0 with ps_dm_cslt=1 and dma_req=1 → all outputs 0. Release reset → core granted the same cycle.
- Core read alone: ps_dm_cslt=1, wrb=1, add=0x0010, memory returns 0xBEEF → arb_dm_add=0x0010; next cycle ps_rvld=1, ps_rdt=0xBEEF, dma_rvld=0.
- DMA idle-slot write: ps_dm_cslt=0, dma_req=1, wrb=0, add=0x0020, wdt=0x1234 → dma_gnt=1, arb_dm_wdt=0x1234, arb_dm_wrb=0; starve_cnt stays 0.
- Starvation with STARVE_LIMIT=4: both requests held for 4 cycles → dma_gnt=0 on cycles 1-4; cycle 5 dma_gnt=1 and arb_ps_stall=1; cycle 6 core granted and stall=0.
- Interleaved reads: core reads 0x0001 (data 0xAAAA), DMA reads 0x0002 (data 0x5555) in the next idle cycle → ps_rvld then dma_rvld on consecutive cycles with the correct data.
- Async reset during FORCE: reset asserted mid-cycle → outputs 0 immediately, stall drops, no rvld pulse follows release.
